// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the CPU
// memory stage (port A) and the loader/debug DMA master (port B).
// Default policy: A has fixed priority, B overrides once it has waited
// STARVE_LIMIT cycles. Build macro DMEM_ARB_RR_EN replaces that with
// round-robin on contention (last-granted port loses).
// Each access takes IDLE/RESP -> ACCESS -> RESP; ack is seen two cycles after
// the request is latched. Addresses >= IO_BASE never strobe the memory.
module dmem_arbiter #(
  parameter int               DBITS        = 32,
  parameter int               ADDR_BITS    = 11,
  parameter int               STARVE_LIMIT = 4,
  parameter logic [DBITS-1:0] IO_BASE      = 32'hF000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [DBITS-1:0]     a_addr,
  input  logic [DBITS-1:0]     a_wdata,
  output logic [DBITS-1:0]     a_rdata,
  output logic                 a_ack,
  output logic                 a_err,
  output logic                 a_stall,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [DBITS-1:0]     b_addr,
  input  logic [DBITS-1:0]     b_wdata,
  output logic [DBITS-1:0]     b_rdata,
  output logic                 b_ack,
  output logic                 b_err,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_wdata,
  input  logic [DBITS-1:0]     mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;     // 1'b1 = port B owns the access
  logic                 we_q, we_d;           // access is a write
  logic                 rej_q, rej_d;         // access was outside memory range
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DBITS-1:0]     mem_wdata_q, mem_wdata_d;

  logic                 cand_a_s, cand_b_s, tie_b_s;
  logic                 sel_valid_s, sel_b_s, sel_we_s, sel_rej_s;
  logic [DBITS-1:0]     sel_addr_s, sel_wdata_s;
  logic                 resp_s;

`ifdef DMEM_ARB_RR_EN
  logic last_b_q, last_b_d;                   // 1'b1 = B was granted last

  // Round-robin tie-break: the port not granted last wins
  always_comb begin
    tie_b_s = ~last_b_q;
    if (sel_valid_s) begin
      last_b_d = sel_b_s;
    end else begin
      last_b_d = last_b_q;
    end
  end

  // Last-grant register, starts as B so that A wins the first contention
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  // Starvation override and saturating wait counter for port B
  always_comb begin
    tie_b_s = (starve_q >= SW'(STARVE_LIMIT));
    if (!b_req || (sel_valid_s && sel_b_s)) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Ports eligible this cycle: both in IDLE, only the non-acked port in RESP
  always_comb begin
    cand_a_s = 1'b0;
    cand_b_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cand_a_s = a_req;
        cand_b_s = b_req;
      end
      ST_RESP: begin
        cand_a_s = a_req & owner_q;
        cand_b_s = b_req & ~owner_q;
      end
      default: begin
        cand_a_s = 1'b0;
        cand_b_s = 1'b0;
      end
    endcase
  end

  // Pick the winner and mux its request fields
  always_comb begin
    sel_valid_s = cand_a_s | cand_b_s;
    if (cand_a_s && cand_b_s) begin
      sel_b_s = tie_b_s;
    end else begin
      sel_b_s = cand_b_s;
    end
    if (sel_b_s) begin
      sel_we_s    = b_we;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
    sel_rej_s = (sel_addr_s >= IO_BASE);
  end

  // Next-state logic: latch a winner onto the memory port, then respond
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    rej_d       = rej_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (sel_valid_s) begin
          state_d     = ST_ACCESS;
          owner_d     = sel_b_s;
          we_d        = sel_we_s;
          rej_d       = sel_rej_s;
          mem_en_d    = ~sel_rej_s;
          mem_we_d    = sel_we_s & ~sel_rej_s;
          mem_addr_d  = sel_addr_s[ADDR_BITS+1:2];
          mem_wdata_d = sel_wdata_s;
        end else begin
          state_d  = ST_IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_RESP;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // FSM state, access bookkeeping and registered memory port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      rej_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      rej_q       <= rej_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Response decode; an owner that dropped its request gets no ack
  always_comb begin
    resp_s = (state_q == ST_RESP);
    a_ack  = resp_s & ~owner_q & a_req;
    b_ack  = resp_s & owner_q & b_req;
    a_err  = a_ack & rej_q;
    b_err  = b_ack & rej_q;
    if (a_ack && !we_q && !rej_q) begin
      a_rdata = mem_rdata;
    end else begin
      a_rdata = '0;
    end
    if (b_ack && !we_q && !rej_q) begin
      b_rdata = mem_rdata;
    end else begin
      b_rdata = '0;
    end
    a_stall = a_req & ~a_ack;
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory, a timestamp-based transaction
// model compared against the DUT every negative clock edge, plus directed
// scenarios with hand-computed literal expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ack, a_err, a_stall, b_ack, b_err;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM seen by the DUT
  logic [31:0] ram [0:2047];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 32'h0;
      ram[16]    <= 32'hDEADBEEF;
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // A transaction latched at the edge closing cycle L strobes memory in L+1
  // and responds in L+2; a new latch is possible from L+2 on (in L+2 only by
  // the other port).
  int          cyc, t_latch, starve;
  bit          t_port, t_we, t_rej, last_b;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [31:0] mdl_mem [0:2047];

  task automatic mdl_reset();
    cyc = 0; t_latch = -100; starve = 0; last_b = 1'b1;
    t_port = 1'b0; t_we = 1'b0; t_rej = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0; t_rdata = 32'h0;
  endtask

  task automatic mdl_edge();
    int c;
    bit ca, cb, pick_b, free;
    c = cyc;
    if (c == t_latch + 1 && !t_rej) begin
      if (t_we) mdl_mem[t_addr[12:2]] = t_wdata;
      else      t_rdata = mdl_mem[t_addr[12:2]];
    end
    free = (c >= t_latch + 2);
    ca = a_req && free && !(c == t_latch + 2 && t_port == 1'b0);
    cb = b_req && free && !(c == t_latch + 2 && t_port == 1'b1);
    if (ca && cb) begin
`ifdef DMEM_ARB_RR_EN
      pick_b = !last_b;
`else
      pick_b = (starve >= 4);
`endif
    end else begin
      pick_b = cb;
    end
    if (!b_req || ((ca || cb) && pick_b)) starve = 0;
    else if (starve < 4) starve = starve + 1;
    if (ca || cb) begin
      t_latch = c;
      t_port  = pick_b;
      last_b  = pick_b;
      t_we    = pick_b ? b_we : a_we;
      t_addr  = pick_b ? b_addr : a_addr;
      t_wdata = pick_b ? b_wdata : a_wdata;
      t_rej   = (t_addr >= 32'hF0000000);
    end
    cyc = c + 1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mdl_mem[i] = 32'h0;
    mdl_mem[16] = 32'hDEADBEEF;
    mdl_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) mdl_reset();
      else mdl_edge();
    end
  end

  task automatic compare_cycle();
    bit acc, rsp, ea, eb;
    if (!reset) begin
      chk1("rst_a_ack", a_ack, 1'b0);
      chk1("rst_b_ack", b_ack, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_a_stall", a_stall, a_req);
    end else begin
      acc = (cyc == t_latch + 1);
      rsp = (cyc == t_latch + 2);
      chk1("mdl_mem_en", mem_en, acc && !t_rej);
      chk1("mdl_mem_we", mem_we, acc && !t_rej && t_we);
      if (acc && !t_rej) begin
        chk32("mdl_mem_addr", 32'(mem_addr), 32'(t_addr[12:2]));
        if (t_we) chk32("mdl_mem_wdata", mem_wdata, t_wdata);
      end
      ea = rsp && !t_port && a_req;
      eb = rsp && t_port && b_req;
      chk1("mdl_a_ack", a_ack, ea);
      chk1("mdl_b_ack", b_ack, eb);
      chk1("mdl_a_err", a_err, ea && t_rej);
      chk1("mdl_b_err", b_err, eb && t_rej);
      chk32("mdl_a_rdata", a_rdata, (ea && !t_we && !t_rej) ? t_rdata : 32'h0);
      chk32("mdl_b_rdata", b_rdata, (eb && !t_we && !t_rej) ? t_rdata : 32'h0);
      chk1("mdl_a_stall", a_stall, a_req && !ea);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_cycle();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd,
                           output bit er, output int lat);
    if (port) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (port ? b_ack : a_ack) begin
        lat = k;
        rd  = port ? b_rdata : a_rdata;
        er  = port ? b_err : a_err;
        break;
      end
      step();
    end
    step();
    if (port) b_req = 1'b0; else a_req = 1'b0;
    chk1("ack_seen", lat >= 0, 1'b1);
  endtask

  task automatic contention(output int a_at, output int b_at);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h100;
    a_at = -1; b_at = -1;
    for (int k = 0; k < 8; k++) begin
      #2;
      if (a_ack && a_at < 0) a_at = k;
      if (b_ack && b_at < 0) b_at = k;
      step();
      if (a_at >= 0) a_req = 1'b0;
      if (b_at >= 0) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, a_at, b_at, a_cnt, a_after;

    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
    step(); step();
    // Reset state: outputs low, stall follows a_req
    a_req = 1'b1; #2;
    chk1("rst_stall_follows_1", a_stall, 1'b1);
    chk1("rst_ack_low", a_ack, 1'b0);
    a_req = 1'b0; #1;
    chk1("rst_stall_follows_0", a_stall, 1'b0);
    step(); reset = 1'b1;
    step();

    // T1: A read of word 16
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40; a_wdata = 32'h0;
    #2; chk1("t1_stall_c0", a_stall, 1'b1); chk1("t1_ack_c0", a_ack, 1'b0);
    step(); #2;
    chk1("t1_mem_en_c1", mem_en, 1'b1);
    chk32("t1_mem_addr_c1", 32'(mem_addr), 32'd16);
    chk1("t1_stall_c1", a_stall, 1'b1);
    step(); #2;
    chk1("t1_ack_c2", a_ack, 1'b1);
    chk32("t1_rdata_c2", a_rdata, 32'hDEADBEEF);
    chk1("t1_stall_c2", a_stall, 1'b0);
    step(); a_req = 1'b0; #2;
    chk1("t1_ack_c3", a_ack, 1'b0);
    step();

    // T2: B write then read back
    do_access(1'b1, 1'b1, 32'h100, 32'h12345678, rd, er, lat);
    chk1("t2_wr_err", er, 1'b0); chk32("t2_wr_lat", 32'(lat), 32'd2);
    do_access(1'b1, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk1("t2_rd_err", er, 1'b0); chk32("t2_rd_data", rd, 32'h12345678);

    // T3: simultaneous requests, A first then B back to back
    contention(a_at, b_at);
    chk32("t3_a_ack_cycle", 32'(a_at), 32'd2);
    chk32("t3_b_ack_cycle", 32'(b_at), 32'd4);

    // T4: A re-requests continuously while B waits
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h100;
    b_at = -1; a_cnt = 0; a_after = -1;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (a_ack) begin
        a_cnt++;
        if (b_at >= 0 && a_after < 0) a_after = k;
      end
      if (b_ack && b_at < 0) b_at = k;
      step();
      if (b_at >= 0) b_req = 1'b0;
    end
    a_req = 1'b0; #2;
    chk1("t4_ack_suppressed", a_ack, 1'b0);
    chk32("t4_b_ack_cycle", 32'(b_at), 32'd4);
    chk32("t4_a_after_b", 32'(a_after), 32'd6);
    chk32("t4_a_ack_count", 32'(a_cnt), 32'd3);
    step(); step();

    // T5: out-of-range read and range boundary
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'hF0000004;
    #2; chk1("t5_mem_en_c0", mem_en, 1'b0);
    step(); #2; chk1("t5_mem_en_c1", mem_en, 1'b0);
    step(); #2;
    chk1("t5_ack_c2", b_ack, 1'b1); chk1("t5_err_c2", b_err, 1'b1);
    chk32("t5_rdata_c2", b_rdata, 32'h0);
    step(); b_req = 1'b0;
    do_access(1'b0, 1'b1, 32'hEFFFFFFC, 32'hCAFEF00D, rd, er, lat);
    chk1("t5_top_wr_err", er, 1'b0);
    do_access(1'b0, 1'b0, 32'hEFFFFFFC, 32'h0, rd, er, lat);
    chk32("t5_top_rd_data", rd, 32'hCAFEF00D);
    do_access(1'b0, 1'b1, 32'hF0000000, 32'h1, rd, er, lat);
    chk1("t5_base_wr_err", er, 1'b1);

    // T6: reset during ACCESS of an A write aborts it
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h40; a_wdata = 32'h55AA55AA;
    step(); #1;
    chk1("t6_mem_en_access", mem_en, 1'b1);
    reset = 1'b0; #1;
    chk1("t6_mem_en_async", mem_en, 1'b0);
    chk1("t6_mem_we_async", mem_we, 1'b0);
    a_req = 1'b0;
    step(); #2; chk1("t6_no_ack", a_ack, 1'b0);
    step(); reset = 1'b1;
    step();
    do_access(1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk32("t6_idle_latency", 32'(lat), 32'd2);
    chk32("t6_write_aborted", rd, 32'hDEADBEEF);

    // T7: contention straight after reset, then again
    contention(a_at, b_at);
    chk32("t7_a_first", 32'(a_at), 32'd2);
    chk32("t7_b_second", 32'(b_at), 32'd4);
    contention(a_at, b_at);
    chk32("t7_a_next", 32'(a_at), 32'd2);
    chk32("t7_b_next", 32'(b_at), 32'd4);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
